// File: rtl/mig_cmd_arbiter.sv
// Two-requester weighted round-robin arbiter for a single MIG user command port.
// Issues one registered cmd_en strobe per grant, then a GAP cycle so cmd_full is re-sampled.
module mig_cmd_arbiter #(
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned MAX_CONSEC = 1
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  enable,
  input  logic                  reqA_valid,
  input  logic [2:0]            reqA_instr,
  input  logic [5:0]            reqA_bl,
  input  logic [ADDR_WIDTH-1:0] reqA_byte_addr,
  output logic                  reqA_ack,
  input  logic                  reqB_valid,
  input  logic [2:0]            reqB_instr,
  input  logic [5:0]            reqB_bl,
  input  logic [ADDR_WIDTH-1:0] reqB_byte_addr,
  output logic                  reqB_ack,
  output logic                  cmd_en,
  output logic [2:0]            cmd_instr,
  output logic [5:0]            cmd_bl,
  output logic [ADDR_WIDTH-1:0] cmd_byte_addr,
  input  logic                  cmd_full,
  input  logic                  cmd_empty,
  output logic                  busy,
  output logic [15:0]           issued_a,
  output logic [15:0]           issued_b
);

  localparam int unsigned InstrW  = 3;
  localparam int unsigned BlW     = 6;
  localparam int unsigned CntW    = 16;
  localparam int unsigned ConsecW = 4;

  localparam logic [InstrW-1:0]  InstrIdle = InstrW'(5);
  localparam logic [ConsecW-1:0] MaxConsec = ConsecW'(MAX_CONSEC);
  localparam logic [ConsecW-1:0] ConsecSat = ConsecW'(15);
  localparam logic               LastB     = 1'b1;

  typedef enum logic {ISSUE_WAIT, GAP} state_e;

  state_e                  state_q, state_d;
  logic                    cmd_en_q, cmd_en_d;
  logic [InstrW-1:0]       cmd_instr_q, cmd_instr_d;
  logic [BlW-1:0]          cmd_bl_q, cmd_bl_d;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
  logic                    ack_a_q, ack_a_d;
  logic                    ack_b_q, ack_b_d;
  logic                    busy_q, busy_d;
  logic [CntW-1:0]         issued_a_q, issued_a_d;
  logic [CntW-1:0]         issued_b_q, issued_b_d;
  logic                    last_q, last_d;
  logic [ConsecW-1:0]      consec_q, consec_d;

  logic                    any_req;
  logic                    keep_last;
  logic                    win_b;

  // consec==0 means no grant yet, so a first tie goes to the requester opposite last (A)
  assign any_req   = reqA_valid || reqB_valid;
  assign keep_last = (consec_q != '0) && (consec_q < MaxConsec);
  assign win_b     = (reqA_valid && reqB_valid) ? (keep_last ? last_q : ~last_q) : reqB_valid;

  always_comb begin
    state_d     = state_q;
    cmd_en_d    = 1'b0;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    cmd_instr_d = cmd_instr_q;
    cmd_bl_d    = cmd_bl_q;
    cmd_addr_d  = cmd_addr_q;
    issued_a_d  = issued_a_q;
    issued_b_d  = issued_b_q;
    last_d      = last_q;
    consec_d    = consec_q;
    busy_d      = any_req || cmd_en_q || !cmd_empty;

    case (state_q)
      ISSUE_WAIT: begin
        if (any_req && !cmd_full) begin
          state_d     = GAP;
          cmd_en_d    = 1'b1;
          cmd_instr_d = win_b ? reqB_instr : reqA_instr;
          cmd_bl_d    = win_b ? reqB_bl : reqA_bl;
          cmd_addr_d  = win_b ? reqB_byte_addr : reqA_byte_addr;
          if (win_b) begin
            ack_b_d    = 1'b1;
            issued_b_d = issued_b_q + CntW'(1);
          end else begin
            ack_a_d    = 1'b1;
            issued_a_d = issued_a_q + CntW'(1);
          end
          if (win_b == last_q) begin
            consec_d = (consec_q == ConsecSat) ? consec_q : consec_q + ConsecW'(1);
          end else begin
            last_d   = win_b;
            consec_d = ConsecW'(1);
          end
        end
      end
      GAP: begin
        state_d = ISSUE_WAIT;
      end
      default: begin
        state_d = ISSUE_WAIT;
      end
    endcase

    // Synchronous clear overrides everything, including a grant decided this cycle
    if (!enable) begin
      state_d     = ISSUE_WAIT;
      cmd_en_d    = 1'b0;
      ack_a_d     = 1'b0;
      ack_b_d     = 1'b0;
      cmd_instr_d = InstrIdle;
      cmd_bl_d    = '0;
      cmd_addr_d  = '0;
      issued_a_d  = '0;
      issued_b_d  = '0;
      last_d      = LastB;
      consec_d    = '0;
      busy_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ISSUE_WAIT;
      cmd_en_q    <= 1'b0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      cmd_instr_q <= InstrIdle;
      cmd_bl_q    <= '0;
      cmd_addr_q  <= '0;
      issued_a_q  <= '0;
      issued_b_q  <= '0;
      last_q      <= LastB;
      consec_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_en_q    <= cmd_en_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      cmd_instr_q <= cmd_instr_d;
      cmd_bl_q    <= cmd_bl_d;
      cmd_addr_q  <= cmd_addr_d;
      issued_a_q  <= issued_a_d;
      issued_b_q  <= issued_b_d;
      last_q      <= last_d;
      consec_q    <= consec_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_en        = cmd_en_q;
  assign cmd_instr     = cmd_instr_q;
  assign cmd_bl        = cmd_bl_q;
  assign cmd_byte_addr = cmd_addr_q;
  assign reqA_ack      = ack_a_q;
  assign reqB_ack      = ack_b_q;
  assign busy          = busy_q;
  assign issued_a      = issued_a_q;
  assign issued_b      = issued_b_q;

endmodule
